// File: rtl/q1_inverse_search.sv
// Purpose : sequential inverse of the byte-level Q1 permutation; scans all 256
//           candidates against an internal forward Q1 and reports the lowest
//           preimage together with the preimage count.
// Latency : 256 cycles from acceptance to out_valid with a full scan. With
//           Q1INV_EARLY_EXIT_EN defined it is k+1 cycles when the lowest
//           preimage is k, and 256 cycles when no byte matches.
// Backpressure: out_ready=0 holds DONE with stable outputs. in_ready is low
//           from acceptance until the result has been taken.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   in_valid/in_ready/in_data   target Q1 output byte, valid/ready handshake
//   out_valid/out_ready         result handshake; the result is held until taken
//   out_data                    lowest X with Q1(X)==target (0x00 if none)
//   out_found                   at least one preimage exists
//   out_count                   number of preimages (0..256)
// Optional macro: Q1INV_EARLY_EXIT_EN -- stop the scan at the first match.

module q1_inverse_search (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_found,
    output logic [8:0] out_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  target_q, target_d;
    logic [8:0]  cand_q, cand_d;      // 9 bits, so 255 -> 256 cannot wrap back to 0
    logic [8:0]  count_q, count_d;
    logic        found_q, found_d;
    logic [7:0]  data_q, data_d;
    logic        hit;

    function automatic logic [3:0] t0(input logic [3:0] n);
        case (n)
            4'h0: t0 = 4'h2; 4'h1: t0 = 4'h8; 4'h2: t0 = 4'hB; 4'h3: t0 = 4'hD;
            4'h4: t0 = 4'hF; 4'h5: t0 = 4'h7; 4'h6: t0 = 4'h6; 4'h7: t0 = 4'hE;
            4'h8: t0 = 4'h3; 4'h9: t0 = 4'h1; 4'hA: t0 = 4'h9; 4'hB: t0 = 4'h4;
            4'hC: t0 = 4'h0; 4'hD: t0 = 4'hA; 4'hE: t0 = 4'hC; default: t0 = 4'h5;
        endcase
    endfunction

    function automatic logic [3:0] t1(input logic [3:0] n);
        case (n)
            4'h0: t1 = 4'h1; 4'h1: t1 = 4'hE; 4'h2: t1 = 4'h2; 4'h3: t1 = 4'hB;
            4'h4: t1 = 4'h4; 4'h5: t1 = 4'hC; 4'h6: t1 = 4'h3; 4'h7: t1 = 4'h7;
            4'h8: t1 = 4'h6; 4'h9: t1 = 4'hD; 4'hA: t1 = 4'hA; 4'hB: t1 = 4'h5;
            4'hC: t1 = 4'hF; 4'hD: t1 = 4'h9; 4'hE: t1 = 4'h0; default: t1 = 4'h8;
        endcase
    endfunction

    function automatic logic [3:0] t2(input logic [3:0] n);
        case (n)
            4'h0: t2 = 4'h4; 4'h1: t2 = 4'hC; 4'h2: t2 = 4'h7; 4'h3: t2 = 4'h5;
            4'h4: t2 = 4'h1; 4'h5: t2 = 4'h6; 4'h6: t2 = 4'h9; 4'h7: t2 = 4'hA;
            4'h8: t2 = 4'h0; 4'h9: t2 = 4'hE; 4'hA: t2 = 4'hD; 4'hB: t2 = 4'h8;
            4'hC: t2 = 4'h2; 4'hD: t2 = 4'hB; 4'hE: t2 = 4'h3; default: t2 = 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] t3(input logic [3:0] n);
        case (n)
            4'h0: t3 = 4'hB; 4'h1: t3 = 4'h9; 4'h2: t3 = 4'h5; 4'h3: t3 = 4'h1;
            4'h4: t3 = 4'hC; 4'h5: t3 = 4'h3; 4'h6: t3 = 4'hD; 4'h7: t3 = 4'hE;
            4'h8: t3 = 4'h6; 4'h9: t3 = 4'h4; 4'hA: t3 = 4'h7; 4'hB: t3 = 4'hF;
            4'hC: t3 = 4'h2; 4'hD: t3 = 4'h0; 4'hE: t3 = 4'h8; default: t3 = 4'hA;
        endcase
    endfunction

    function automatic logic [3:0] ror1(input logic [3:0] n);
        ror1 = {n[0], n[3:1]};
    endfunction

    // Forward Q1. (8*a)%16 keeps only a[0] in the top bit. b3 mixes a1, not a2,
    // which is why the map need not be a bijection.
    function automatic logic [7:0] q1_fwd(input logic [7:0] x);
        logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3;
        a0 = x[7:4];
        b0 = x[3:0];
        a1 = a0 ^ b0;
        b1 = a0 ^ ror1(b0) ^ {a0[0], 3'b000};
        a2 = t0(a1);
        b2 = t1(b1);
        a3 = a2 ^ b2;
        b3 = a1 ^ ror1(b2) ^ {a2[0], 3'b000};
        q1_fwd = {t3(b3), t2(a3)};
    endfunction

    assign hit = (q1_fwd(cand_q[7:0]) == target_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= 8'h00;
            cand_q   <= 9'd0;
            count_q  <= 9'd0;
            found_q  <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cand_q   <= cand_d;
            count_q  <= count_d;
            found_q  <= found_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cand_d   = cand_q;
        count_d  = count_q;
        found_d  = found_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    target_d = in_data;
                    cand_d   = 9'd0;
                    count_d  = 9'd0;
                    found_d  = 1'b0;
                    data_d   = 8'h00;   // a scan with no match reports 0x00
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                cand_d = cand_q + 9'd1;
                if (hit) begin
                    count_d = count_q + 9'd1;
                    if (!found_q) begin
                        found_d = 1'b1;
                        data_d  = cand_q[7:0];
                    end
                end
`ifdef Q1INV_EARLY_EXIT_EN
                // First match ends the scan; count is then exactly 1.
                if (hit || cand_q == 9'd255) begin
                    state_d = DONE;
                end
`else
                if (cand_q == 9'd255) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_found = found_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_q1_inverse_search.sv
module tb_q1_inverse_search;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_found;
    logic [8:0] out_count;

    q1_inverse_search dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_found (out_found),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef Q1INV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    // Reference: forward Q1 from the nibble formula, then a full inverse table.
    int T0[16] = '{2, 8, 11, 13, 15, 7, 6, 14, 3, 1, 9, 4, 0, 10, 12, 5};
    int T1[16] = '{1, 14, 2, 11, 4, 12, 3, 7, 6, 13, 10, 5, 15, 9, 0, 8};
    int T2[16] = '{4, 12, 7, 5, 1, 6, 9, 10, 0, 14, 13, 8, 2, 11, 3, 15};
    int T3[16] = '{11, 9, 5, 1, 12, 3, 13, 14, 6, 4, 7, 15, 2, 0, 8, 10};

    function automatic int rotr(input int n);
        return ((n >> 1) | ((n & 1) << 3)) & 15;
    endfunction

    function automatic int q1m(input int x);
        int a0, b0, a1, b1, a2, b2, a3, b3;
        a0 = x / 16;          b0 = x % 16;
        a1 = a0 ^ b0;         b1 = a0 ^ rotr(b0) ^ ((8 * a0) % 16);
        a2 = T0[a1];          b2 = T1[b1];
        a3 = a2 ^ b2;         b3 = a1 ^ rotr(b2) ^ ((8 * a2) % 16);
        return 16 * T3[b3] + T2[a3];
    endfunction

    int pre_cnt[256];
    int pre_low[256];

    function automatic int latency(input int t);
        return (EARLY && pre_cnt[t] != 0) ? pre_low[t] + 1 : 256;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic [8:0] c;
        int         rise;
    } exp_t;

    exp_t sb[$];
    int   hs_cyc  = 0;
    int   sum_cnt = 0;

    task automatic submit(input int t, output int acc);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = t[7:0];
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            acc = -1;
            in_valid = 1'b0;
            return;
        end
        acc    = cyc + 1;
        e.f    = (pre_cnt[t] != 0);
        e.d    = e.f ? pre_low[t][7:0] : 8'h00;
        e.c    = EARLY ? {8'd0, e.f} : pre_cnt[t][8:0];
        e.rise = acc + latency(t);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_out_found"}, out_found, 0);
        chk({tag, "_out_count"}, out_count, 0);
    endtask

    // Monitor: compares every cycle the DUT presents a result, pops on handshake.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    if (!prev) chk("rise_cycle", cyc, sb[0].rise);
                    chk("out_data",  out_data,  sb[0].d);
                    chk("out_found", out_found, sb[0].f);
                    chk("out_count", out_count, sb[0].c);
                    chk("in_ready_in_done", in_ready, 0);
                    if (out_ready) begin
                        sum_cnt += out_count;
                        hs_cyc = cyc + 1;
                        void'(sb.pop_front());
                    end
                end
            end
            prev = out_valid;
        end
    end

    initial begin
        int acc, prev_acc, prev_lat, nop, exp_sum, n;

        for (int y = 0; y < 256; y++) pre_cnt[y] = 0;
        for (int x = 255; x >= 0; x--) begin
            pre_cnt[q1m(x)]++;
            pre_low[q1m(x)] = x;
        end
        chk("model_q1_00", q1m(0), 'h65);
        chk("model_q1_01", q1m(1), 'h53);

        // Reset state, async (no clock edge yet).
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Known targets, then a target without any preimage.
        submit('h65, acc);
        submit('h53, acc);
        nop = 'h65;
        for (int y = 255; y >= 0; y--) if (pre_cnt[y] == 0) nop = y;
        submit(nop, acc);
        drain();

        // Backpressure: hold DONE while offering a new byte.
        @(posedge clk); #1 out_ready = 1'b0;
        submit($urandom_range(0, 255), acc);
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached_done", out_valid, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        submit('h53, acc);
        chk("accept_after_release", acc, hs_cyc + 1);
        drain();

        // Reset mid-scan, then a fresh request.
        submit('h65, acc);
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs("midscan_rst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        submit('h65, acc);
        drain();

        // Back-to-back sweep over every target.
        sum_cnt = 0;
        exp_sum = 0;
        prev_acc = 0;
        prev_lat = 0;
        for (int t = 0; t < 256; t++) begin
            submit(t, acc);
            if (t > 0) chk("b2b_spacing", acc - prev_acc, prev_lat + 2);
            prev_acc = acc;
            prev_lat = latency(t);
            exp_sum += EARLY ? (pre_cnt[t] != 0 ? 1 : 0) : pre_cnt[t];
        end
        drain();
        chk("count_sum", sum_cnt, exp_sum);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
